// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory access unit: op encodings,
// FSM states and per-op beat counts.
package lsu_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  // Index of the final beat; the beat counter runs 0..LAST.
  localparam logic [1:0] WORD_LAST_BEAT = 2'd3;
  localparam logic [1:0] BYTE_LAST_BEAT = 2'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  function automatic logic is_word_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_store_op(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic [1:0] last_beat(input logic [2:0] op);
    return is_word_op(op) ? WORD_LAST_BEAT : BYTE_LAST_BEAT;
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Load/store unit bridging the EX/MEM request to a byte-wide memory.
// Words move as four big-endian byte beats, bytes as a single beat.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned word ops are flagged
// with resp_err and skip the memory; otherwise their low address bits are
// forced to 00 and resp_err stays 0.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              Enable,
  output logic              ReadWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [7:0]        DataIn,
  input  logic [7:0]        DataOut
);

  state_e            state, state_nxt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        beat_q;
  logic [31:0]       data_q;

  logic              accept;
  logic              misaligned_trap;
  logic              skip_access;
  logic [ADDR_W-1:0] req_addr_eff;

  assign accept      = req_valid && (state == S_IDLE);
  assign skip_access = !is_valid_op(req_op) || misaligned_trap;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign misaligned_trap = is_word_op(req_op) && (req_addr[1:0] != 2'b00);
  assign req_addr_eff    = req_addr;
  assign resp_err        = (state == S_RESP) && err_q;
`else
  assign misaligned_trap = 1'b0;
  assign req_addr_eff    = is_word_op(req_op) ? {req_addr[ADDR_W-1:2], 2'b00} : req_addr;
  assign resp_err        = 1'b0;
`endif

  // State register; async reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch, beat counter and read-data shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      data_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr_eff;
      wdata_q <= req_wdata;
      beat_q  <= '0;
      data_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= misaligned_trap;
`endif
    end else if (state == S_ACCESS) begin
      beat_q <= beat_q + 2'd1;
      // Shifting in from the bottom leaves beat 0 in the MSBs after four beats.
      if (!is_store_op(op_q)) begin
        data_q <= {data_q[23:0], DataOut};
      end
    end
  end

  // Next-state and all combinational outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = (state == S_IDLE);
    stall      = (state != S_IDLE) || req_valid;
    resp_valid = 1'b0;
    resp_rdata = '0;
    Enable     = 1'b0;
    ReadWrite  = 1'b1;
    Address    = '0;
    DataIn     = '0;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = skip_access ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        Enable    = 1'b1;
        ReadWrite = !is_store_op(op_q);
        Address   = addr_q + {{(ADDR_W-2){1'b0}}, beat_q};
        if (is_store_op(op_q)) begin
          if (is_word_op(op_q)) begin
            case (beat_q)
              2'd0:    DataIn = wdata_q[31:24];
              2'd1:    DataIn = wdata_q[23:16];
              2'd2:    DataIn = wdata_q[15:8];
              default: DataIn = wdata_q[7:0];
            endcase
          end else begin
            DataIn = wdata_q[7:0];
          end
        end
        if (beat_q == last_beat(op_q)) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        case (op_q)
          OP_LW:   resp_rdata = data_q;
          OP_LB:   resp_rdata = {{24{data_q[7]}}, data_q[7:0]};
          OP_LBU:  resp_rdata = {24'h0, data_q[7:0]};
          default: resp_rdata = '0;
        endcase
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, a
// reset-during-store sequence, and randomized ops against a reference model.
module tb_mem_access_unit;

  localparam int AW    = 10;
  localparam int MEMSZ = 1 << AW;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [2:0] LW = 3'b000, LB = 3'b001, LBU = 3'b010, SW = 3'b100, SB = 3'b101;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          stall;
  logic          Enable;
  logic          ReadWrite;
  logic [AW-1:0] Address;
  logic [7:0]    DataIn;
  logic [7:0]    DataOut;

  int n_tests = 0;
  int n_fail  = 0;
  int enable_cnt = 0;

  logic [7:0] mem     [0:MEMSZ-1];
  logic [7:0] ref_mem [0:MEMSZ-1];

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall), .Enable(Enable), .ReadWrite(ReadWrite),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  // Attached byte memory: asynchronous read, write on the edge ending a beat.
  assign DataOut = mem[Address];
  always @(posedge clk) begin
    if (Enable && !ReadWrite) mem[Address] <= DataIn;
  end

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] <= 8'(i * 37 + 11);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  // Memory-side outputs must be quiet whenever no beat is running.
  always @(negedge clk) begin
    if (Enable === 1'b1) begin
      enable_cnt++;
    end else begin
      check_bit("idle_readwrite", ReadWrite, 1'b1);
      check("idle_address", 32'(Address), 32'h0);
      check("idle_datain", 32'(DataIn), 32'h0);
    end
  end

  // Reference model: applies one op to ref_mem and predicts the response.
  task automatic model_op(input logic [2:0] op, input logic [AW-1:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat, output int beats);
    int base;
    rd = 32'h0; err = 1'b0; lat = 1; beats = 0;
    case (op)
      LW, SW: begin
        if (TRAP && addr[1:0] != 2'b00) begin
          err = 1'b1;
        end else begin
          base = int'(addr) - (int'(addr) % 4);
          lat = 5; beats = 4;
          for (int k = 0; k < 4; k++) begin
            if (op == SW) ref_mem[(base + k) % MEMSZ] = 8'(wd >> (8 * (3 - k)));
            else rd = (rd << 8) | 32'(ref_mem[(base + k) % MEMSZ]);
          end
        end
      end
      LB:  begin lat = 2; beats = 1; rd = 32'($signed(ref_mem[addr])); end
      LBU: begin lat = 2; beats = 1; rd = 32'(ref_mem[addr]); end
      SB:  begin lat = 2; beats = 1; ref_mem[addr] = wd[7:0]; end
      default: ;
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_beats);
    int guard;
    int lat;
    bit got;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    check_bit({name, ":ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    enable_cnt = 0;
    #1 check_bit({name, ":stall_accept"}, stall, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = 3'b000; req_addr = '0; req_wdata = '0;
    lat = 0; got = 0; rd = '0; er = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      check_bit({name, ":stall_busy"}, stall, 1'b1);
      check_bit({name, ":ready_busy"}, req_ready, 1'b0);
      if (resp_valid) begin got = 1; rd = resp_rdata; er = resp_err; end
    end
    check({name, ":latency"}, 32'(lat), 32'(exp_lat));
    check({name, ":rdata"}, rd, exp_rd);
    check_bit({name, ":err"}, er, exp_err);
    @(negedge clk);
    check({name, ":beats"}, 32'(enable_cnt), 32'(exp_beats));
    check_bit({name, ":resp_pulse"}, resp_valid, 1'b0);
    check_bit({name, ":stall_idle"}, stall, 1'b0);
    check_bit({name, ":ready_idle"}, req_ready, 1'b1);
    check({name, ":mem"}, 32'(mem_diffs()), 32'h0);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    int            exp_lat;
    int            exp_beats;
  } vec_t;

  vec_t vecs [13];

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] mrd;
    logic        merr;
    int          mlat, mbeats;

    vecs[0]  = '{SW,  10'h010, 32'h11223344, 32'h00000000, 1'b0, 5, 4};
    vecs[1]  = '{LW,  10'h010, 32'h0,        32'h11223344, 1'b0, 5, 4};
    vecs[2]  = '{SB,  10'h020, 32'h12345685, 32'h00000000, 1'b0, 2, 1};
    vecs[3]  = '{LB,  10'h020, 32'h0,        32'hFFFFFF85, 1'b0, 2, 1};
    vecs[4]  = '{LBU, 10'h020, 32'h0,        32'h00000085, 1'b0, 2, 1};
    vecs[5]  = TRAP ? '{SW, 10'h3FE, 32'hAABBCCDD, 32'h0, 1'b1, 1, 0}
                    : '{SW, 10'h3FE, 32'hAABBCCDD, 32'h0, 1'b0, 5, 4};
    vecs[6]  = '{SW,  10'h3FC, 32'hAABBCCDD, 32'h00000000, 1'b0, 5, 4};
    vecs[7]  = '{LW,  10'h3FC, 32'h0,        32'hAABBCCDD, 1'b0, 5, 4};
    vecs[8]  = '{SB,  10'h3FF, 32'hFFFFFF5A, 32'h00000000, 1'b0, 2, 1};
    vecs[9]  = '{LW,  10'h3FC, 32'h0,        32'hAABBCC5A, 1'b0, 5, 4};
    vecs[10] = TRAP ? '{LW, 10'h013, 32'h0, 32'h00000000, 1'b1, 1, 0}
                    : '{LW, 10'h013, 32'h0, 32'h11223344, 1'b0, 5, 4};
    vecs[11] = '{3'b011, 10'h040, 32'hDEADBEEF, 32'h00000000, 1'b0, 1, 0};
    vecs[12] = '{LB,  10'h3FF, 32'h0,        32'h0000005A, 1'b0, 2, 1};

    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'(i * 37 + 11);

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    #3;
    check_bit("rst_req_ready", req_ready, 1'b1);
    check_bit("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check_bit("rst_resp_err", resp_err, 1'b0);
    check_bit("rst_stall", stall, 1'b0);
    check_bit("rst_enable", Enable, 1'b0);
    check_bit("rst_readwrite", ReadWrite, 1'b1);
    check("rst_address", 32'(Address), 32'h0);
    check("rst_datain", 32'(DataIn), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      model_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, mrd, merr, mlat, mbeats);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_beats);
    end
    check("bytes_010", {mem[16], mem[17], mem[18], mem[19]}, 32'h11223344);
    check("bytes_3fc", {mem[1020], mem[1021], mem[1022], mem[1023]}, 32'hAABBCC5A);

    // Reset during beat 2 of a store: only the first two bytes land.
    @(negedge clk);
    req_valid = 1'b1; req_op = SW; req_addr = 10'h100; req_wdata = 32'hCAFEF00D;
    enable_cnt = 0;
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #2 check_bit("abort_enable_before", Enable, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("abort_enable_drop", Enable, 1'b0);
    check_bit("abort_ready", req_ready, 1'b1);
    check_bit("abort_stall", stall, 1'b0);
    check_bit("abort_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[10'h100] = 8'hCA;
    ref_mem[10'h101] = 8'hFE;
    repeat (3) @(negedge clk);
    check_bit("abort_ready_after", req_ready, 1'b1);
    check("abort_beats", 32'(enable_cnt), 32'd2);
    check("abort_byte102", 32'(mem[10'h102]), 32'(ref_mem[10'h102]));
    check("abort_byte103", 32'(mem[10'h103]), 32'(ref_mem[10'h103]));
    check("abort_mem", 32'(mem_diffs()), 32'h0);
    model_op(LW, 10'h100, 32'h0, mrd, merr, mlat, mbeats);
    run_op("after_abort_lw", LW, 10'h100, 32'h0, mrd, merr, mlat, mbeats);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]    op;
      logic [AW-1:0] addr;
      logic [31:0]   wd;
      case ($urandom_range(0, 9))
        0, 1:    op = LW;
        2:       op = LB;
        3:       op = LBU;
        4, 5:    op = SW;
        6:       op = SB;
        7:       op = 3'b011;
        8:       op = 3'b110;
        default: op = 3'b111;
      endcase
      addr = AW'($urandom);
      wd   = $urandom;
      model_op(op, addr, wd, mrd, merr, mlat, mbeats);
      run_op($sformatf("rnd%0d", i), op, addr, wd, mrd, merr, mlat, mbeats);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
